g11620_line_capture: RTL and testbench
======================================

Name: g11620_line_capture

Overview:
- Downstream of the G11620 sequencer: captures the digitized video samples of one 512-pixel readout into one of two line banks (ping-pong) and hands completed lines to the host reader.
- Triggered by the sensor's ad_sp pulse.
- Flags overrun when both banks still hold unread lines.

Parameters:
PIX_NUM, 9'd511, index of last pixel; a line is PIX_NUM+1 samples
ADC_W, 16, ADC sample width
SKIP_CYC, 2, ADC pipeline latency in clk cycles between ad_sp and pixel 0 (0..15)

Ports:
clk  in  1  capture clock, same clock as the sequencer
rst_n  in  1  asynchronous active-low reset
soft_reset_in  in  1  synchronous abort; clears all state
cap_en_in  in  1  level; capture enabled
ad_sp  in  1  sensor start-of-pixel-stream pulse
adc_data  in  ADC_W  ADC sample, valid every clk during a line
line_ready_o  out  1  1-cycle pulse: a bank was committed
rd_bank_o  out  1  bank currently owned by the host
rd_avail_o  out  1  rd_bank_o holds an unread line
rd_en_in  in  1  host read strobe
rd_addr_in  in  9  pixel index
rd_data_o  out  ADC_W  read data, 1-cycle latency
rd_valid_o  out  1  rd_en_in delayed 1 cycle
line_release_in  in  1  host finished with rd_bank_o
line_cnt_o  out  16  committed lines, wraps 0xFFFF->0
overrun_o  out  1  sticky; set on a dropped line
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_n low or soft_reset_in high) clears all outputs to 0 and sets state=IDLE, wr_bank=0, rd_bank=0, bank_full=2'b00. soft_reset_in has priority over every other input.
- IDLE: when cap_en_in=1, go to WAIT_SP.
- WAIT_SP:
  - ad_sp=1 and bank_full[wr_bank]=0: go to SKIP with skip_cnt=0, or straight to CAPTURE if SKIP_CYC=0.
  - ad_sp=1 and bank_full[wr_bank]=1: set overrun_o, stay in WAIT_SP, drop the line.
  - cap_en_in=0: go to IDLE.
- SKIP: skip_cnt increments each cycle; at skip_cnt==SKIP_CYC-1, go to CAPTURE.
- CAPTURE:
  - Write adc_data to bank wr_bank at address pix_cnt every cycle. pix_cnt runs 0..PIX_NUM.
  - Pixel 0 is the sample present SKIP_CYC+1 clocks after the edge on which ad_sp is sampled high.
  - ad_sp pulses during CAPTURE are ignored.
  - At pix_cnt==PIX_NUM, go to COMMIT.
- COMMIT (1 cycle): bank_full[wr_bank]<=1, line_ready_o=1, line_cnt_o++, wr_bank toggles. Next state: WAIT_SP if cap_en_in=1, else IDLE.
- cap_en_in falling mid-line: the line completes, then the block goes to IDLE.
- rd_avail_o = bank_full[rd_bank].
- line_release_in with rd_avail_o=1: clear bank_full[rd_bank] and toggle rd_bank. With rd_avail_o=0 it is ignored.
- Release and COMMIT in the same cycle always target different banks; both take effect.
- Reads are always allowed; rd_data_o is undefined when rd_avail_o=0. rd_data_o holds its value when rd_en_in=0.
- RAM: write port owned by the capture path, read port owned by the host; no arbitration needed.
- overrun_o clears only on reset or soft reset.

Optional Feature:
- Macro G11620_LINE_STATS_EN.
- Defined: adds outputs line_min_o[ADC_W] and line_max_o[ADC_W].
  - Running min/max are computed over the CAPTURE samples, seeded by pixel 0.
  - They are registered to the outputs in COMMIT, alongside line_ready_o.
  - Outputs reset to 0.
- Undefined: the ports and logic are absent.

Decomposition:
- Package g11620_pkg holds the state encoding (IDLE=0, WAIT_SP=1, SKIP=2, CAPTURE=3, COMMIT=4) and the LINE_DEPTH=512 constant.
- Sub-module g11620_line_ram: simple dual-port RAM, 1024 x ADC_W, with address {bank, pixel}, 1-cycle registered read. Inferred as block RAM.

Test Plan:
- Single line, SKIP_CYC=2:
  - Stimulus: cap_en=1, ad_sp pulse at cycle T, adc_data = cycle count.
  - Required: bank0[0] = value at T+3, bank0[511] = value at T+514; line_ready_o pulses once; line_cnt_o=1; rd_avail_o=1; rd_bank_o=0.
- Readback:
  - Stimulus: rd_en with addr 0..511.
  - Required: rd_valid_o and rd_data_o one cycle later, matching the written ramp. After release: rd_avail_o=0, rd_bank_o=1.
- Overrun:
  - Stimulus: capture 2 lines with no release, then a 3rd ad_sp.
  - Required: overrun_o=1; line_cnt_o stays 2; bank contents unchanged.
- Release and commit in the same cycle:
  - Stimulus: pulse line_release_in on the COMMIT cycle of line 2.
  - Required: bank_full=2'b10; rd_bank_o=1; no overrun.
- Soft reset at pix_cnt=200:
  - Required: state IDLE next cycle; bank_full=0; line_cnt_o=0; no line_ready_o.
- Stats (G11620_LINE_STATS_EN defined):
  - Stimulus: line of 0x0100 with pixel 37=0x0005 and pixel 400=0xFFF0.
  - Required: line_min_o=0x0005, line_max_o=0xFFF0.

Source files
------------

// File: rtl/g11620_pkg.sv
// rtl/g11620_pkg.sv - state encoding, line depth and bank addressing for the G11620 line capture
package g11620_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_SP = 3'd1,
    ST_SKIP    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_COMMIT  = 3'd4
  } cap_state_t;

  localparam int LINE_DEPTH = 512;

  // RAM address is {bank, pixel}: each bank holds one full line
  function automatic logic [9:0] ram_addr(input logic bank, input logic [8:0] pix);
    return {bank, pix};
  endfunction

endpackage

// File: rtl/g11620_line_capture_if.sv
// rtl/g11620_line_capture_if.sv - host-side line hand-off and read port
interface g11620_line_capture_if #(
  parameter int ADC_W = 16
);
  logic             line_ready_o;
  logic             rd_bank_o;
  logic             rd_avail_o;
  logic             rd_en_in;
  logic [8:0]       rd_addr_in;
  logic [ADC_W-1:0] rd_data_o;
  logic             rd_valid_o;
  logic             line_release_in;

  modport slave (
    output line_ready_o, rd_bank_o, rd_avail_o, rd_data_o, rd_valid_o,
    input  rd_en_in, rd_addr_in, line_release_in
  );

  modport master (
    input  line_ready_o, rd_bank_o, rd_avail_o, rd_data_o, rd_valid_o,
    output rd_en_in, rd_addr_in, line_release_in
  );
endinterface

// File: rtl/g11620_line_ram.sv
// rtl/g11620_line_ram.sv - two-bank simple dual-port line RAM with registered read
module g11620_line_ram #(
  parameter int ADC_W = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [ADC_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [ADC_W-1:0] rd_data
);

  logic [ADC_W-1:0] mem [0:DEPTH-1];

  // no reset on the read register so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/g11620_line_capture.sv
// rtl/g11620_line_capture.sv - ping-pong capture of one 512-pixel readout per ad_sp pulse
// Optional line min/max outputs: G11620_LINE_STATS_EN
module g11620_line_capture
  import g11620_pkg::*;
#(
  parameter logic [8:0] PIX_NUM  = 9'd511,
  parameter int         ADC_W    = 16,
  parameter int         SKIP_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             soft_reset_in,
  input  logic             cap_en_in,
  input  logic             ad_sp,
  input  logic [ADC_W-1:0] adc_data,
  g11620_line_capture_if.slave host,
  output logic [15:0]      line_cnt_o,
  output logic             overrun_o,
  output logic             busy_o
`ifdef G11620_LINE_STATS_EN
  ,
  output logic [ADC_W-1:0] line_min_o,
  output logic [ADC_W-1:0] line_max_o
`endif
);

  localparam logic [3:0] SKIP_LAST = 4'(SKIP_CYC - 1);

  cap_state_t state, state_nxt;
  logic [3:0] skip_cnt;
  logic [8:0] pix_cnt;
  logic       wr_bank;
  logic       rd_bank;
  logic [1:0] bank_full, bank_full_nxt;
  logic       rd_valid;
  logic       start, drop, release_ok, wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             state <= ST_IDLE;
    else if (soft_reset_in) state <= ST_IDLE;
    else                    state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    drop       = 1'b0;
    wr_en      = 1'b0;
    release_ok = host.line_release_in && bank_full[rd_bank];
    case (state)
      ST_IDLE: if (cap_en_in) state_nxt = ST_WAIT_SP;
      ST_WAIT_SP: begin
        if (ad_sp && !bank_full[wr_bank]) begin
          start     = 1'b1;
          state_nxt = (SKIP_CYC == 0) ? ST_CAPTURE : ST_SKIP;
        end else if (ad_sp) begin
          drop = 1'b1;
        end else if (!cap_en_in) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SKIP: if (skip_cnt == SKIP_LAST) state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        wr_en = 1'b1;
        if (pix_cnt == PIX_NUM) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: state_nxt = cap_en_in ? ST_WAIT_SP : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // a same-cycle release and commit always hit different banks
    bank_full_nxt = bank_full;
    if (release_ok) bank_full_nxt[rd_bank] = 1'b0;
    if (state == ST_COMMIT) bank_full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt   <= '0;
      pix_cnt    <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      bank_full  <= 2'b00;
      line_cnt_o <= '0;
      overrun_o  <= 1'b0;
      rd_valid   <= 1'b0;
    end else if (soft_reset_in) begin
      skip_cnt   <= '0;
      pix_cnt    <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      bank_full  <= 2'b00;
      line_cnt_o <= '0;
      overrun_o  <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      if (start)                 skip_cnt <= '0;
      else if (state == ST_SKIP) skip_cnt <= skip_cnt + 4'd1;
      if (start || state == ST_COMMIT) pix_cnt <= '0;
      else if (state == ST_CAPTURE)    pix_cnt <= pix_cnt + 9'd1;
      if (state == ST_COMMIT) begin
        wr_bank    <= ~wr_bank;
        line_cnt_o <= line_cnt_o + 16'd1;
      end
      if (release_ok) rd_bank <= ~rd_bank;
      bank_full <= bank_full_nxt;
      if (drop) overrun_o <= 1'b1;
      rd_valid <= host.rd_en_in;
    end
  end

  g11620_line_ram #(
    .ADC_W (ADC_W),
    .DEPTH (2 * LINE_DEPTH),
    .AW    (10)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (ram_addr(wr_bank, pix_cnt)),
    .wr_data (adc_data),
    .rd_en   (host.rd_en_in),
    .rd_addr (ram_addr(rd_bank, host.rd_addr_in)),
    .rd_data (host.rd_data_o)
  );

  assign host.line_ready_o = (state == ST_COMMIT);
  assign host.rd_bank_o    = rd_bank;
  assign host.rd_avail_o   = bank_full[rd_bank];
  assign host.rd_valid_o   = rd_valid;
  assign busy_o            = (state != ST_IDLE);

`ifdef G11620_LINE_STATS_EN
  logic [ADC_W-1:0] run_min, run_max;

  // pixel 0 seeds the running extremes; published while line_ready_o is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_min <= '0; run_max <= '0; line_min_o <= '0; line_max_o <= '0;
    end else if (soft_reset_in) begin
      run_min <= '0; run_max <= '0; line_min_o <= '0; line_max_o <= '0;
    end else begin
      if (state == ST_CAPTURE) begin
        run_min <= (pix_cnt == 9'd0 || adc_data < run_min) ? adc_data : run_min;
        run_max <= (pix_cnt == 9'd0 || adc_data > run_max) ? adc_data : run_max;
      end
      if (state == ST_COMMIT) begin
        line_min_o <= run_min;
        line_max_o <= run_max;
      end
    end
  end
`endif

endmodule

// File: tb/tb_g11620_line_capture.sv
// tb/tb_g11620_line_capture.sv - scoreboard bench for g11620_line_capture
module tb_g11620_line_capture;

  localparam int SKIP = 2;
  localparam int NPIX = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        soft_reset_in;
  logic        cap_en_in;
  logic        ad_sp;
  logic [15:0] adc_data;
  logic [15:0] line_cnt_o;
  logic        overrun_o;
  logic        busy_o;
`ifdef G11620_LINE_STATS_EN
  logic [15:0] line_min_o, line_max_o;
`endif

  g11620_line_capture_if #(.ADC_W(16)) bus ();

  g11620_line_capture #(
    .PIX_NUM  (9'd511),
    .ADC_W    (16),
    .SKIP_CYC (SKIP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .soft_reset_in (soft_reset_in),
    .cap_en_in     (cap_en_in),
    .ad_sp         (ad_sp),
    .adc_data      (adc_data),
    .host          (bus),
    .line_cnt_o    (line_cnt_o),
    .overrun_o     (overrun_o),
    .busy_o        (busy_o)
`ifdef G11620_LINE_STATS_EN
    ,
    .line_min_o    (line_min_o),
    .line_max_o    (line_max_o)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ecnt     = 0;
  bit          stats_mode = 0;
  int          line_t0  = 0;
  logic [15:0] exp_bank [2][NPIX];
  logic [15:0] rd_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ramp mode: sample value equals the edge it is captured on
  function automatic logic [15:0] adc_val(input int k);
    int p;
    if (!stats_mode) return 16'(k);
    p = k - line_t0;
    if (p == 37)  return 16'h0005;
    if (p == 400) return 16'hFFF0;
    return 16'h0100;
  endfunction

  task automatic step();
    @(posedge clk);
    ecnt++;
    #1;
    adc_data = adc_val(ecnt + 1);
  endtask

  always @(negedge clk) begin
    if (bus.rd_valid_o) begin
      if (rd_q.size() == 0) check("rd_valid_unexpected", 1, 0);
      else check("rd_data", bus.rd_data_o, rd_q.pop_front());
    end
  end

  task automatic capture_line(input bit stats, input bit rel_at_commit, input int b);
    int  t;
    bit  seen;
    t          = ecnt + 1;
    stats_mode = stats;
    line_t0    = t + SKIP + 1;
    for (int p = 0; p < NPIX; p++) exp_bank[b][p] = adc_val(line_t0 + p);
    ad_sp = 1'b1;
    step();
    ad_sp = 1'b0;
    seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      step();
      if (bus.line_ready_o) seen = 1;
    end
    check("commit_seen", 32'(seen), 1);
    check("commit_edge", ecnt, line_t0 + NPIX - 1);
    if (rel_at_commit) bus.line_release_in = 1'b1;
    step();
    bus.line_release_in = 1'b0;
    check("ready_one_cycle", 32'(bus.line_ready_o), 0);
    stats_mode = 0;
  endtask

  task automatic read_bank(input int b);
    for (int p = 0; p < NPIX; p++) begin
      bus.rd_en_in   = 1'b1;
      bus.rd_addr_in = 9'(p);
      rd_q.push_back(exp_bank[b][p]);
      step();
    end
    bus.rd_en_in = 1'b0;
    step();
    step();
    check("rd_drain", rd_q.size(), 0);
    check("rd_hold", bus.rd_data_o, exp_bank[b][NPIX-1]);
  endtask

  task automatic release_line();
    bus.line_release_in = 1'b1;
    step();
    bus.line_release_in = 1'b0;
  endtask

  initial begin
    int t;
    int pulses;
    rst_n = 1'b0; soft_reset_in = 1'b0; cap_en_in = 1'b0; ad_sp = 1'b0;
    adc_data = 16'h0; bus.rd_en_in = 1'b0; bus.rd_addr_in = 9'h0; bus.line_release_in = 1'b0;
    step(); step(); step();
    check("rst_busy", 32'(busy_o), 0);
    check("rst_ready", 32'(bus.line_ready_o), 0);
    check("rst_avail", 32'(bus.rd_avail_o), 0);
    check("rst_rd_bank", 32'(bus.rd_bank_o), 0);
    check("rst_line_cnt", 32'(line_cnt_o), 0);
    check("rst_overrun", 32'(overrun_o), 0);
    check("rst_rd_valid", 32'(bus.rd_valid_o), 0);
    rst_n = 1'b1;
    step();
    cap_en_in = 1'b1;
    step(); step();
    check("busy_wait_sp", 32'(busy_o), 1);

    // line 1 into bank 0, read back, release
    capture_line(0, 0, 0);
    check("l1_cnt", 32'(line_cnt_o), 1);
    check("l1_avail", 32'(bus.rd_avail_o), 1);
    check("l1_rd_bank", 32'(bus.rd_bank_o), 0);
    read_bank(0);
    release_line();
    check("rel_avail", 32'(bus.rd_avail_o), 0);
    check("rel_rd_bank", 32'(bus.rd_bank_o), 1);

    // line 2 into bank 1, line 3 (stats pattern) into bank 0 with release on commit
    capture_line(0, 0, 1);
    check("l2_cnt", 32'(line_cnt_o), 2);
    check("l2_avail", 32'(bus.rd_avail_o), 1);
    capture_line(1, 1, 0);
    check("l3_cnt", 32'(line_cnt_o), 3);
    check("l3_rd_bank", 32'(bus.rd_bank_o), 0);
    check("l3_avail", 32'(bus.rd_avail_o), 1);
    check("l3_overrun", 32'(overrun_o), 0);
`ifdef G11620_LINE_STATS_EN
    check("stats_min", 32'(line_min_o), 32'h0005);
    check("stats_max", 32'(line_max_o), 32'hFFF0);
`endif
    read_bank(0);

    // fill bank 1 too, then a third ad_sp must be dropped
    capture_line(0, 0, 1);
    check("l4_cnt", 32'(line_cnt_o), 4);
    check("l4_overrun_clear", 32'(overrun_o), 0);
    ad_sp = 1'b1;
    step();
    ad_sp = 1'b0;
    check("overrun_set", 32'(overrun_o), 1);
    pulses = 0;
    for (int i = 0; i < 530; i++) begin
      step();
      if (bus.line_ready_o) pulses++;
    end
    check("overrun_no_commit", pulses, 0);
    check("overrun_cnt", 32'(line_cnt_o), 4);
    check("overrun_sticky", 32'(overrun_o), 1);
    read_bank(0);

    // free bank 0, start a line and abort it at pixel 200
    release_line();
    check("pre_sr_rd_bank", 32'(bus.rd_bank_o), 1);
    t = ecnt + 1;
    ad_sp = 1'b1;
    step();
    ad_sp = 1'b0;
    while (ecnt < t + SKIP + 1 + 199) step();
    soft_reset_in = 1'b1;
    step();
    soft_reset_in = 1'b0;
    check("sr_idle", 32'(busy_o), 0);
    check("sr_avail", 32'(bus.rd_avail_o), 0);
    check("sr_rd_bank", 32'(bus.rd_bank_o), 0);
    check("sr_cnt", 32'(line_cnt_o), 0);
    check("sr_overrun", 32'(overrun_o), 0);
    check("sr_ready", 32'(bus.line_ready_o), 0);
    pulses = 0;
    for (int i = 0; i < 520; i++) begin
      step();
      if (bus.line_ready_o) pulses++;
    end
    check("sr_no_commit", pulses, 0);

    // capture restarts cleanly in bank 0
    capture_line(0, 0, 0);
    check("post_sr_cnt", 32'(line_cnt_o), 1);
    check("post_sr_rd_bank", 32'(bus.rd_bank_o), 0);
    check("post_sr_avail", 32'(bus.rd_avail_o), 1);
    read_bank(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
